// File: rtl/microwave_timer_if.sv
// Front-panel and display signal bundle for the microwave countdown controller.
// The master side drives the tick, buttons and door; the slave side (the timer) drives time and status.
interface microwave_timer_if;
  logic       tick_in;
  logic       btn_add_min;
  logic       btn_add_10s;
  logic       btn_start;
  logic       btn_stop;
  logic       door_open;
  logic [3:0] minutes;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic [2:0] state;
  logic       magnetron;
  logic       beep;

  modport master (
    output tick_in, btn_add_min, btn_add_10s, btn_start, btn_stop, door_open,
    input  minutes, sec_tens, sec_ones, state, magnetron, beep
  );

  modport slave (
    input  tick_in, btn_add_min, btn_add_10s, btn_start, btn_stop, door_open,
    output minutes, sec_tens, sec_ones, state, magnetron, beep
  );
endinterface

// File: rtl/microwave_timer.sv
// Microwave countdown controller: BCD M:SS cook time, five-state control FSM,
// seconds derived from the clock divider's slow tick, magnetron and beeper control.
module microwave_timer #(
  parameter int unsigned TICKS_PER_SEC = 196,
  parameter int unsigned BEEP_SECS     = 3
) (
  input logic              clock_in,
  input logic              reset,
  microwave_timer_if.slave bus
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam int unsigned BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BEEP_MAX  = BW'(BEEP_SECS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      st;
  logic [3:0]  min_q;
  logic [2:0]  tens_q;
  logic [3:0]  ones_q;
  logic [PW-1:0] presc;
  logic [BW-1:0] beep_cnt;
  logic        tick_prev, amin_prev, a10_prev, start_prev, stop_prev;

  logic tick_rise, amin_rise, a10_rise, start_rise, stop_rise;
  logic counting, sec_strobe, time_zero, start_ok, any_rise, dec_zero;
  logic [3:0] min_plus;
  logic [3:0] a10_min, dec_min;
  logic [2:0] a10_tens, dec_tens;
  logic [3:0] a10_ones, dec_ones;

  assign tick_rise  = bus.tick_in     & ~tick_prev;
  assign amin_rise  = bus.btn_add_min & ~amin_prev;
  assign a10_rise   = bus.btn_add_10s & ~a10_prev;
  assign start_rise = bus.btn_start   & ~start_prev;
  assign stop_rise  = bus.btn_stop    & ~stop_prev;

  assign counting   = (st == RUN) || (st == DONE);
  assign sec_strobe = counting && tick_rise && (presc == PRESC_MAX);
  assign time_zero  = (min_q == 4'd0) && (tens_q == 3'd0) && (ones_q == 4'd0);
  assign start_ok   = start_rise & ~bus.door_open;
  assign any_rise   = amin_rise | a10_rise | start_rise | stop_rise;
  assign dec_zero   = (min_q == 4'd0) && (tens_q == 3'd0) && (ones_q == 4'd1);

  // Saturating BCD increments and borrow-propagating decrement of the cook time
  always_comb begin
    min_plus = (min_q == 4'd9) ? 4'd9 : min_q + 4'd1;

    a10_min  = min_q;
    a10_tens = tens_q + 3'd1;
    a10_ones = ones_q;
    if (tens_q == 3'd5) begin
      if (min_q == 4'd9) begin
        a10_tens = 3'd5;
        a10_ones = 4'd9;
      end else begin
        a10_min  = min_q + 4'd1;
        a10_tens = 3'd0;
      end
    end

    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q - 4'd1;
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      if (tens_q != 3'd0) begin
        dec_tens = tens_q - 3'd1;
      end else begin
        dec_tens = 3'd5;
        dec_min  = min_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      st         <= IDLE;
      min_q      <= 4'd0;
      tens_q     <= 3'd0;
      ones_q     <= 4'd0;
      presc      <= '0;
      beep_cnt   <= '0;
      tick_prev  <= 1'b1;
      amin_prev  <= 1'b1;
      a10_prev   <= 1'b1;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
    end else begin
      tick_prev  <= bus.tick_in;
      amin_prev  <= bus.btn_add_min;
      a10_prev   <= bus.btn_add_10s;
      start_prev <= bus.btn_start;
      stop_prev  <= bus.btn_stop;

      if (!counting) begin
        presc <= '0;
      end else if (tick_rise) begin
        presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
      end

      if (st != DONE) begin
        beep_cnt <= '0;
      end

      // Highest-priority applicable event wins; lower ones are dropped this cycle
      case (st)
        IDLE: begin
          if (start_ok) begin
            min_q  <= 4'd0;
            tens_q <= 3'd3;
            ones_q <= 4'd0;
            st     <= RUN;
          end else if (amin_rise) begin
            min_q <= min_plus;
            st    <= SET;
          end else if (a10_rise) begin
            min_q  <= a10_min;
            tens_q <= a10_tens;
            ones_q <= a10_ones;
            st     <= SET;
          end
        end
        SET, PAUSE: begin
          if (stop_rise) begin
            min_q  <= 4'd0;
            tens_q <= 3'd0;
            ones_q <= 4'd0;
            st     <= IDLE;
          end else if (start_ok && !time_zero) begin
            st <= RUN;
          end else if (amin_rise) begin
            min_q <= min_plus;
          end else if (a10_rise) begin
            min_q  <= a10_min;
            tens_q <= a10_tens;
            ones_q <= a10_ones;
          end
        end
        RUN: begin
          if (bus.door_open || stop_rise) begin
            st <= PAUSE;
          end else if (sec_strobe) begin
            min_q  <= dec_min;
            tens_q <= dec_tens;
            ones_q <= dec_ones;
            if (dec_zero) begin
              st <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.door_open || any_rise) begin
            min_q  <= 4'd0;
            tens_q <= 3'd0;
            ones_q <= 4'd0;
            st     <= IDLE;
          end else if (sec_strobe) begin
            if (beep_cnt == BEEP_MAX) begin
              beep_cnt <= '0;
              min_q    <= 4'd0;
              tens_q   <= 3'd0;
              ones_q   <= 4'd0;
              st       <= IDLE;
            end else begin
              beep_cnt <= beep_cnt + BW'(1);
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.minutes   = min_q;
  assign bus.sec_tens  = tens_q;
  assign bus.sec_ones  = ones_q;
  assign bus.state     = st;
  // Door cuts heating in the same cycle, before the FSM reaches PAUSE
  assign bus.magnetron = (st == RUN) & ~bus.door_open;
  assign bus.beep      = (st == DONE);

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer: directed vector table, hand sequences for countdown,
// saturation, door and reset corners, and random stimulus against a seconds-based model.
module tb_microwave_timer;

  localparam int TPS = 4;
  localparam int BS  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  microwave_timer_if bus ();

  microwave_timer #(
    .TICKS_PER_SEC(TPS),
    .BEEP_SECS    (BS)
  ) dut (
    .clock_in(clk),
    .reset   (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int r, tick, amin, a10, start, stop, door;
    int es, em, et, eo, emag, ebeep;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(int r, int tick, int amin, int a10, int start, int stop, int door,
                              int es, int em, int et, int eo, int emag, int ebeep);
    vec_t v;
    v.r = r; v.tick = tick; v.amin = amin; v.a10 = a10; v.start = start; v.stop = stop; v.door = door;
    v.es = es; v.em = em; v.et = et; v.eo = eo; v.emag = emag; v.ebeep = ebeep;
    return v;
  endfunction

  task automatic check(input string name, input int es, input int em, input int et, input int eo,
                       input int emag, input int ebeep);
    checks++;
    if ({bus.state, bus.minutes, bus.sec_tens, bus.sec_ones, bus.magnetron, bus.beep} !==
        {3'(es), 4'(em), 3'(et), 4'(eo), 1'(emag), 1'(ebeep)}) begin
      errors++;
      $display("FAIL %s: got st=%0d %0d:%0d%0d mag=%0d beep=%0d, want st=%0d %0d:%0d%0d mag=%0d beep=%0d",
               name, bus.state, bus.minutes, bus.sec_tens, bus.sec_ones, bus.magnetron, bus.beep,
               es, em, et, eo, emag, ebeep);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int tick, input int amin, input int a10, input int start,
                        input int stop, input int door);
    bus.tick_in     = 1'(tick);
    bus.btn_add_min = 1'(amin);
    bus.btn_add_10s = 1'(a10);
    bus.btn_start   = 1'(start);
    bus.btn_stop    = 1'(stop);
    bus.door_open   = 1'(door);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // which: 0 add_min, 1 add_10s, 2 start, 3 stop
  task automatic press(input int which);
    case (which)
      0: bus.btn_add_min = 1'b1;
      1: bus.btn_add_10s = 1'b1;
      2: bus.btn_start   = 1'b1;
      default: bus.btn_stop = 1'b1;
    endcase
    cyc();
    bus.btn_add_min = 1'b0;
    bus.btn_add_10s = 1'b0;
    bus.btn_start   = 1'b0;
    bus.btn_stop    = 1'b0;
    cyc();
  endtask

  task automatic tick_rises(input int n);
    for (int k = 0; k < n; k++) begin
      bus.tick_in = 1'b1;
      cyc();
      bus.tick_in = 1'b0;
      cyc();
    end
  endtask

  // Reference model: cook time held as whole seconds, state as the spec's numeric codes
  int ms, mt, mticks, mbeeps;
  bit p_tick, p_am, p_a10, p_st, p_sp;

  function automatic int add_minute(input int t);
    return (t / 60 < 9) ? t + 60 : t;
  endfunction

  function automatic int add_ten(input int t);
    return (t / 60 == 9 && (t % 60) / 10 == 5) ? 599 : t + 10;
  endfunction

  task automatic model_edge(input bit r, input bit tick, input bit am, input bit a10,
                            input bit st, input bit sp, input bit door);
    bit tr, ram, r10, rs, rsp, strobe, running;
    if (r) begin
      ms = 0; mt = 0; mticks = 0; mbeeps = 0;
      p_tick = 1; p_am = 1; p_a10 = 1; p_st = 1; p_sp = 1;
      return;
    end
    tr = tick & ~p_tick; ram = am & ~p_am; r10 = a10 & ~p_a10; rs = st & ~p_st; rsp = sp & ~p_sp;
    running = (ms == 2 || ms == 4);
    strobe  = running && tr && (mticks == TPS - 1);
    if (!running) mticks = 0;
    else if (tr) mticks = (mticks + 1) % TPS;
    if (ms != 4) mbeeps = 0;
    case (ms)
      0: begin
        if (rs && !door) begin mt = 30; ms = 2; end
        else if (ram) begin mt = add_minute(mt); ms = 1; end
        else if (r10) begin mt = add_ten(mt); ms = 1; end
      end
      1, 3: begin
        if (rsp) begin mt = 0; ms = 0; end
        else if (rs && !door && mt != 0) ms = 2;
        else if (ram) mt = add_minute(mt);
        else if (r10) mt = add_ten(mt);
      end
      2: begin
        if (door || rsp) ms = 3;
        else if (strobe) begin
          mt = mt - 1;
          if (mt == 0) ms = 4;
        end
      end
      default: begin
        if (door || ram || r10 || rs || rsp) begin ms = 0; mt = 0; end
        else if (strobe) begin
          mbeeps++;
          if (mbeeps == BS) begin ms = 0; mt = 0; mbeeps = 0; end
        end
      end
    endcase
    p_tick = tick; p_am = am; p_a10 = a10; p_st = st; p_sp = sp;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);

    // Directed vectors: one row per clock edge
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 2, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 2, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 3, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 3, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0,  2, 0, 3, 0, 1, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 0,  2, 0, 3, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,  2, 0, 3, 0, 1, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 0,  2, 0, 3, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,  2, 0, 3, 0, 1, 0);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0,  2, 0, 3, 0, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,  2, 0, 3, 0, 1, 0);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 0,  2, 0, 2, 9, 1, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,  2, 0, 2, 9, 1, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 1, 0,  3, 0, 2, 9, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0,  3, 0, 2, 9, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[22] = mk(0, 0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tbl[24] = mk(0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 26; i++) begin
      rst = 1'(tbl[i].r);
      set_in(tbl[i].tick, tbl[i].amin, tbl[i].a10, tbl[i].start, tbl[i].stop, tbl[i].door);
      cyc();
      check($sformatf("vec%0d", i), tbl[i].es, tbl[i].em, tbl[i].et, tbl[i].eo, tbl[i].emag, tbl[i].ebeep);
    end

    // Full countdown from 1:00 through DONE and the beep period
    do_reset();
    press(0);
    check("set_1min", 1, 1, 0, 0, 0, 0);
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
    check("run_1min", 2, 1, 0, 0, 1, 0);
    tick_rises(4);
    check("run_0_59", 2, 0, 5, 9, 1, 0);
    tick_rises(58 * 4);
    check("run_0_01", 2, 0, 0, 1, 1, 0);
    tick_rises(3);
    check("run_0_01_hold", 2, 0, 0, 1, 1, 0);
    tick_rises(1);
    check("done_enter", 4, 0, 0, 0, 0, 1);
    tick_rises(7);
    check("done_beeping", 4, 0, 0, 0, 0, 1);
    tick_rises(1);
    check("done_to_idle", 0, 0, 0, 0, 0, 0);

    // Saturation at 9:59
    do_reset();
    repeat (10) press(0);
    check("sat_9_00", 1, 9, 0, 0, 0, 0);
    repeat (6) press(1);
    check("sat_9_59", 1, 9, 5, 9, 0, 0);
    repeat (2) press(1);
    check("sat_9_59_more", 1, 9, 5, 9, 0, 0);

    // Door opened mid-run
    do_reset();
    repeat (5) press(1);
    press(2);
    tick_rises(20);
    check("door_pre", 2, 0, 4, 5, 1, 0);
    bus.door_open = 1'b1;
    #1;
    check("door_comb", 2, 0, 4, 5, 0, 0);
    cyc();
    check("door_pause", 3, 0, 4, 5, 0, 0);
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
    check("door_start_ign", 3, 0, 4, 5, 0, 0);
    tick_rises(4);
    check("door_pause_hold", 3, 0, 4, 5, 0, 0);
    bus.door_open = 1'b0;
    cyc();
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
    check("door_resume", 2, 0, 4, 5, 1, 0);
    tick_rises(4);
    check("door_resume_dec", 2, 0, 4, 4, 1, 0);

    // Start held across reset release, then quick start, stop with coincident strobe
    rst = 1'b1;
    set_in(0, 0, 0, 1, 0, 0);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    check("held_start", 0, 0, 0, 0, 0, 0);
    bus.btn_start = 1'b0;
    cyc();
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
    check("quick_start", 2, 0, 3, 0, 1, 0);
    tick_rises(3);
    bus.tick_in  = 1'b1;
    bus.btn_stop = 1'b1;
    cyc();
    bus.tick_in  = 1'b0;
    bus.btn_stop = 1'b0;
    check("stop_strobe", 3, 0, 3, 0, 0, 0);
    cyc();
    press(3);
    check("stop_clear", 0, 0, 0, 0, 0, 0);

    // Reset mid-run
    press(2);
    tick_rises(5);
    check("pre_reset", 2, 0, 2, 9, 1, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_reset", 0, 0, 0, 0, 0, 0);

    // Random stimulus against the model; quiet and busy phases alternate
    begin
      bit r, tk, am, a10, st, sp, dr;
      bit busy;
      r = 1; tk = 0; am = 0; a10 = 0; st = 0; sp = 0; dr = 0;
      for (int i = 0; i < 20000; i++) begin
        busy = ((i / 800) % 2) == 1;
        r  = (i == 0) || ($urandom_range(2999, 0) == 0);
        if ($urandom_range(1, 0) == 0) tk = ~tk;
        if ($urandom_range(busy ? 19 : 399, 0) == 0) am  = ~am;
        if ($urandom_range(busy ? 19 : 399, 0) == 0) a10 = ~a10;
        if ($urandom_range(busy ? 19 : 299, 0) == 0) st  = ~st;
        if ($urandom_range(busy ? 19 : 999, 0) == 0) sp  = ~sp;
        if (dr) begin
          if ($urandom_range(19, 0) == 0) dr = 0;
        end else if ($urandom_range(busy ? 99 : 1999, 0) == 0) begin
          dr = 1;
        end
        rst = r;
        set_in(int'(tk), int'(am), int'(a10), int'(st), int'(sp), int'(dr));
        model_edge(r, tk, am, a10, st, sp, dr);
        cyc();
        check($sformatf("rand%0d", i), ms, mt / 60, (mt % 60) / 10, mt % 10,
              (ms == 2 && !dr) ? 1 : 0, (ms == 4) ? 1 : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microwave_timer.md
# microwave_timer

Countdown controller for the microwave oven, sitting directly downstream of the clock divider. It consumes the divider's slow square wave as a synchronous tick and counts whole seconds from it. It keeps the cook time as BCD M:SS (0:00–9:59) and runs a five-state control FSM. It drives the magnetron enable, the end-of-cook beeper and the digit values for the display stage.

## Interface
- TICKS_PER_SEC, 196: `tick_in` rising edges per second (196 ≈ 50 MHz / 255102); must be ≥ 2.
- BEEP_SECS, 3: length of the end-of-cook beep, in seconds.
- clock_in  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- tick_in  input  1  divider output, synchronous to clock_in; only its rising edges are used.
- btn_add_min  input  1  debounced level; each rising edge adds 1 minute.
- btn_add_10s  input  1  debounced level; each rising edge adds 10 seconds.
- btn_start  input  1  debounced level; acts on its rising edge.
- btn_stop  input  1  debounced level; acts on its rising edge.
- door_open  input  1  level; 1 = door open.
- minutes  output  4  BCD, 0–9.
- sec_tens  output  3  0–5.
- sec_ones  output  4  BCD, 0–9.
- state  output  3  IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4.
- magnetron  output  1  heating enable.
- beep  output  1  beeper enable.

## Operation
- Edge detection:
  - `tick_in` and the four buttons each have a previous-sample register.
  - rise = input & ~prev.
  - The prev registers reset to 1, so a signal already high at reset release produces no event.
- Prescaler:
  - Counts tick rises from 0 to TICKS_PER_SEC−1.
  - A tick rise at TICKS_PER_SEC−1 wraps the count to 0 and fires `sec_strobe`.
  - It runs only in RUN and DONE and is held at 0 in every other state.
- Event priority within one cycle: reset > door_open > stop > start > add_min > add_10s. Only the highest-priority applicable event acts.
- add_min:
  - Acts in IDLE, SET and PAUSE.
  - minutes+1, saturating at 9.
  - IDLE→SET.
- add_10s:
  - Acts in IDLE, SET and PAUSE.
  - sec_tens+1. If sec_tens was 5, it wraps to 0 and minutes+1.
  - At minutes=9, sec_tens=5 the time saturates to 9:59.
  - IDLE→SET.
- Add buttons are ignored in RUN and DONE.
- start (door closed only; ignored while door_open=1):
  - IDLE: load 0:30 → RUN.
  - SET or PAUSE with time ≠ 0:00 → RUN.
- stop:
  - RUN→PAUSE, time kept.
  - PAUSE→IDLE and SET→IDLE, time cleared to 0:00.
  - DONE→IDLE.
  - IDLE: no effect.
- door_open=1:
  - In RUN: →PAUSE.
  - In DONE: →IDLE.
  - Other states: no state change; add buttons still act.
- Countdown in RUN:
  - On `sec_strobe`, perform a BCD decrement with borrow (e.g. 1:00→0:59, 0:10→0:09).
  - A decrement from 0:01 gives 0:00 and the transition to DONE.
- DONE:
  - beep=1.
  - After BEEP_SECS `sec_strobe`s, →IDLE with time 0:00.
  - Any button rise in DONE → IDLE immediately.
- Outputs:
  - magnetron = (state==RUN) & ~door_open. This is combinational so the door cuts heat in the same cycle.
  - beep = (state==DONE), registered via state.

## Timing
- Reset values: minutes=0, sec_tens=0, sec_ones=0, state=IDLE, beep=0, magnetron=0. The prescaler and beep-second counter are also 0.
- Button response latency:
  - A button sampled low at edge N−1 and high at edge N registers its action at edge N.
  - The new state/time is visible after edge N.
  - Holding the button produces no further events.
- First decrement after entering RUN: on the TICKS_PER_SEC-th tick rise following entry.
- A PAUSE→RUN resume restarts the prescaler from 0.
- A `sec_strobe` in the same cycle as stop or door_open is discarded (no decrement).
- magnetron falls combinationally with door_open and stays 0 because state moves to PAUSE at the next edge.
- reset asserted mid-RUN: at the next edge all outputs return to reset values.

## Test plan
- Setup: TICKS_PER_SEC=4, BEEP_SECS=2.
  - Press add_10s three times, then start → state SET with 0:30.
  - Then RUN, with first decrement to 0:29 exactly 4 tick rises after start.
- Time 1:00, RUN → after 4 tick rises shows 0:59.
  - Continue to 0:01 → 0:00.
  - state DONE, magnetron=0, beep=1 for 8 tick rises, then IDLE.
- Saturation:
  - 10× add_min → 9:00.
  - 6× add_10s → 9:59, and further presses keep 9:59.
- In RUN at 0:45, raise door_open:
  - magnetron=0 in the same cycle, state PAUSE after the next edge, time 0:45 held.
  - start while door open is ignored.
  - Close door, start → RUN.
- IDLE, start → 0:30 RUN.
  - stop → PAUSE; stop again → IDLE at 0:00.
  - btn_start held high across reset release produces no event.
- btn_stop and btn_start rise in the same cycle during SET → IDLE at 0:00 (stop wins).
